// File: rtl/ising_run_seq.sv
// Multi-run anneal sequencer: resets the oscillator array, settles, samples phase vs spin 0, pushes one spin vector per run.
// Optional macro ISING_SPIN_SYNC_EN adds a 2-flop synchroniser on spins_in.
module ising_run_seq #(
  parameter int N          = 3,
  parameter int CNT_W      = 32,
  parameter int RUN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          ising_rst,
  input  logic                          start,
  input  logic [RUN_W-1:0]              num_runs,
  input  logic [CNT_W-1:0]              counter_cutoff,
  input  logic [CNT_W-1:0]              counter_max,
  input  logic [N-1:0]                  spins_in,
  output logic                          core_rstn,
  output logic                          busy,
  output logic                          done,
  output logic [RUN_W-1:0]              run_idx,
  output logic                          res_valid,
  output logic [N-1:0]                  res_data,
  input  logic                          res_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RST, S_SETTLE, S_SAMPLE, S_COMMIT, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [RCW-1:0]   rc_q, rc_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic [RUN_W-1:0] runs_q, runs_d, run_idx_q, run_idx_d;
  logic [CNT_W-1:0] cut_q, cut_d, max_q, max_d;
  logic             core_rstn_q, core_rstn_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic [N-1:0]     mem_q [FIFO_DEPTH];
  logic [N-1:0]     spin_s;
  logic [N-1:0]     result;
  logic [CNT_W-1:0] win;
  logic             push, push_ok, pop, full;

`ifdef ISING_SPIN_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge ising_rst) begin
    if (ising_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= spins_in;
      sync2_q <= sync1_q;
    end
  end
  assign spin_s = sync2_q;
`else
  assign spin_s = spins_in;
`endif

  // Phase of the run for cycle counter value c (one bit wider so c+1 never wraps).
  function automatic state_t next_phase(input logic [CNT_W:0] c, input logic [CNT_W-1:0] cut,
                                        input logic [CNT_W-1:0] mx);
    logic [CNT_W:0] span;
    span = (mx > cut) ? {1'b0, mx} : {1'b0, cut};
    if (c >= span)                              next_phase = S_COMMIT;
    else if (c >= {1'b0, cut} && c < {1'b0, mx}) next_phase = S_SAMPLE;
    else                                        next_phase = S_SETTLE;
  endfunction

  assign win  = (max_q > cut_q) ? (max_q - cut_q) : '0;
  assign pop  = res_valid && res_ready;
  assign full = (level_q == LW'(FIFO_DEPTH));

  always_comb begin
    result = '0;
    for (int i = 1; i < N; i++) result[i] = ({cnt_q[i], 1'b0} > {1'b0, win});
  end

  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    c_d         = c_q;
    runs_d      = runs_q;
    cut_d       = cut_q;
    max_d       = max_q;
    run_idx_d   = run_idx_q;
    core_rstn_d = core_rstn_q;
    overflow_d  = overflow_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && num_runs != '0) begin
          runs_d      = num_runs;
          cut_d       = counter_cutoff;
          max_d       = counter_max;
          overflow_d  = 1'b0;
          run_idx_d   = '0;
          rc_d        = '0;
          core_rstn_d = 1'b0;
          state_d     = S_RST;
        end
      end
      S_RST: begin
        for (int i = 0; i < N; i++) cnt_d[i] = '0;
        if (rc_q == RCW'(RST_CYCLES - 1)) begin
          core_rstn_d = 1'b1;
          c_d         = '0;
          state_d     = next_phase('0, cut_q, max_q);
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      S_SETTLE, S_SAMPLE: begin
        if (state_q == S_SAMPLE) begin
          for (int i = 1; i < N; i++)
            if (spin_s[i] != spin_s[0] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
        end
        c_d     = c_q + 1'b1;
        state_d = next_phase({1'b0, c_q} + 1'b1, cut_q, max_q);
      end
      S_COMMIT: begin
        push = 1'b1;
        if (run_idx_q == runs_q - RUN_W'(1)) begin
          state_d = S_FIN;
        end else begin
          run_idx_d   = run_idx_q + 1'b1;
          rc_d        = '0;
          core_rstn_d = 1'b0;
          state_d     = S_RST;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A same-cycle pop frees the slot, so only a full FIFO without a pop drops.
    push_ok = push && (!full || pop);
    if (push && full && !pop) overflow_d = 1'b1;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end

  always_ff @(posedge clk or posedge ising_rst) begin
    if (ising_rst) begin
      state_q     <= S_IDLE;
      rc_q        <= '0;
      c_q         <= '0;
      runs_q      <= '0;
      cut_q       <= '0;
      max_q       <= '0;
      run_idx_q   <= '0;
      core_rstn_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      c_q         <= c_d;
      runs_q      <= runs_d;
      cut_q       <= cut_d;
      max_q       <= max_d;
      run_idx_q   <= run_idx_d;
      core_rstn_q <= core_rstn_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      level_q     <= level_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= result;
  end

  assign core_rstn  = core_rstn_q;
  assign busy       = (state_q == S_RST) || (state_q == S_SETTLE) ||
                      (state_q == S_SAMPLE) || (state_q == S_COMMIT);
  assign done       = (state_q == S_FIN);
  assign run_idx    = run_idx_q;
  assign fifo_level = level_q;
  assign res_valid  = (level_q != '0);
  assign res_data   = res_valid ? mem_q[rd_q] : '0;
  assign overflow   = overflow_q;

endmodule

// File: doc/ising_run_seq.md
# ising_run_seq

Multi-run sequencer and sampler for the oscillator array. It owns the array's reset line and repeats a programmable number of anneal runs. Each run settles the array, then measures every spin's phase relative to spin 0 over a sample window, and pushes one N-bit spin vector per run into a result FIFO. It replaces the single-shot free-running sampler at the top level: the oscillator core feeds `spins_in`, and software or an AXI bridge drains the FIFO.

## Interface
Parameters:
- `N`, 3: number of spins/oscillators.
- `CNT_W`, 32: width of cycle and per-spin mismatch counters.
- `RUN_W`, 16: width of run count and run index.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `RST_CYCLES`, 4: cycles `core_rstn` is held low at the start of each run; ≥1.

Ports:
- `clk`  in  1  single clock.
- `ising_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a batch.
- `num_runs`  in  RUN_W  runs per batch; sampled on accepted `start`.
- `counter_cutoff`  in  CNT_W  settle cycles per run; sampled on accepted `start`.
- `counter_max`  in  CNT_W  total cycles per run after release; sampled on accepted `start`.
- `spins_in`  in  N  raw oscillator outputs (asynchronous to `clk`).
- `core_rstn`  out  1  active-low reset to oscillator array.
- `busy`  out  1  batch in progress.
- `done`  out  1  one-cycle pulse at end of batch.
- `run_idx`  out  RUN_W  index of the current run, 0-based.
- `res_valid`  out  1  FIFO head valid.
- `res_data`  out  N  FIFO head spin vector.
- `res_ready`  in  1  pop FIFO head when `res_valid`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: a result was dropped.

## Operation
- FSM states: IDLE → RST → SETTLE → SAMPLE → COMMIT → (RST | FIN) → IDLE.
- IDLE: `start` with `num_runs`≠0 is accepted: latch config, clear `overflow` and `run_idx`, go to RST. `start` with `num_runs`=0 is ignored. `start` outside IDLE is ignored.
- RST: `core_rstn`=0 for RST_CYCLES cycles; all per-spin counters cleared.
- Cycle counter `c` = 0 on the first cycle `core_rstn`=1.
- SETTLE while `c` < cutoff. SAMPLE while cutoff ≤ `c` < max.
- Each SAMPLE cycle, `cnt_i` increments if synchronised spin i ≠ spin 0. Counters saturate at all-ones.
- Window W = max − cutoff if max > cutoff, else 0. If W = 0, SAMPLE is skipped.
- COMMIT (one cycle): result bit i = 1 iff 2·`cnt_i` > W. Bit 0 is always 0. Push to the FIFO.
- After COMMIT, if `run_idx` = `num_runs`−1, go to FIN; otherwise increment `run_idx` and go to RST.
- FIFO full at COMMIT: the result is dropped, `overflow`=1, and the sequence continues.
- A pop in the same cycle frees a slot, so push+pop on a full FIFO succeeds.
- FIN: `done`=1 for one cycle, then IDLE.
- FIFO contents persist across batches; only reset empties them.
- `core_rstn` stays 1 in FIN and IDLE, so the array free-runs after the batch.

## Timing
- Reset values: `core_rstn`=0, `busy`=0, `done`=0, `run_idx`=0, `res_valid`=0, `res_data`=0, `fifo_level`=0, `overflow`=0. The FSM resets to IDLE, so `core_rstn` stays 0 until the first `start`.
- `start` accepted at cycle t: `busy`=1 and `core_rstn`=0 from t+1.
- Per-run length: RST_CYCLES + max(counter_max, counter_cutoff) + 1 (COMMIT) cycles.
- FIFO is first-word-fall-through with a registered head. A push into an empty FIFO gives `res_valid`=1 the cycle after COMMIT. A pop takes effect on the `clk` edge where `res_valid`&&`res_ready`.
- `done` is asserted the cycle after the last COMMIT; `busy` deasserts the same cycle.
- `ising_rst` mid-batch: immediate asynchronous return to reset values. The FIFO is emptied and the batch is abandoned.

## Configuration
- `ISING_SPIN_SYNC_EN` defined: `spins_in` passes through a 2-flop synchroniser per bit, so a spin change is seen by the counters 2 cycles later.
- Undefined: `spins_in` is sampled directly (only for simulation or synchronous sources); latency 0.

## Test plan
- N=3, num_runs=1, cutoff=10, max=30, `spins_in`=3'b010 constant → one entry 3'b010, `fifo_level`=1, one `done` pulse, `core_rstn` low exactly 4 cycles.
- Window 20: spin 2 differs from spin 0 for 10 cycles → bit2=0; for 11 cycles → bit2=1.
- FIFO_DEPTH=4, num_runs=6, `res_ready`=0 → `fifo_level`=4, `overflow`=1, first 4 results retained, `done` still pulses; a second `start` clears `overflow`.
- cutoff=max=8, 3 runs → three entries of 3'b000; each run lasts 4+8+1 cycles.
- `ising_rst` pulse mid-SAMPLE with 2 entries queued → all outputs at reset values, FIFO empty. A `start` pulse during a batch and `start` with `num_runs`=0 are both ignored.
- With `ISING_SPIN_SYNC_EN`: a step on spin 1 at the window edge shifts `cnt_1` by exactly 2 versus the undefined build.
